// File: rtl/mul_pkg.sv
// Shared constants and state type for the sequential 4x4 shift-and-add multiplier.
package mul_pkg;
  localparam int OP_W      = 4;
  localparam int PROD_W    = 8;
  localparam logic [1:0] ITER_LAST = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;
endpackage

// File: rtl/adder_4bit.sv
// 4-bit ripple-carry adder built from a chain of full-adder cells.
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
      assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = carry[4];
endmodule

// File: rtl/mul_4bit_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier with valid/ready on both sides.
// Optional MUL_EARLY_EXIT_EN: a zero operand skips the RUN phase entirely.
module mul_4bit_seq
  import mul_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [OP_W-1:0]   i_a,
  input  logic [OP_W-1:0]   i_b,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [PROD_W-1:0] o_prod
);
  state_t          state_reg, state_next;
  logic [OP_W-1:0] mcand_reg, mcand_next;
  logic [OP_W-1:0] mplr_reg, mplr_next;
  logic [OP_W-1:0] acc_hi_reg, acc_hi_next;
  logic [1:0]      cnt_reg, cnt_next;

  logic [OP_W-1:0] add_b;
  logic [OP_W-1:0] add_sum;
  logic            add_cout;

  assign add_b = mplr_reg[0] ? mcand_reg : '0;

  adder_4bit u_add (
    .a    (acc_hi_reg),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      mplr_reg   <= '0;
      acc_hi_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      mcand_reg  <= mcand_next;
      mplr_reg   <= mplr_next;
      acc_hi_reg <= acc_hi_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    mcand_next  = mcand_reg;
    mplr_next   = mplr_reg;
    acc_hi_next = acc_hi_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (i_valid) begin
          mcand_next  = i_a;
          mplr_next   = i_b;
          acc_hi_next = '0;
          cnt_next    = '0;
          state_next  = RUN;
`ifdef MUL_EARLY_EXIT_EN
          if (i_a == '0 || i_b == '0) begin
            mplr_next  = '0;
            state_next = DONE;
          end
`endif
        end
      end
      RUN: begin
        // Carry-out lands in the top bit and is absorbed by the right shift.
        {acc_hi_next, mplr_next} = {add_cout, add_sum, mplr_reg[OP_W-1:1]};
        cnt_next = cnt_reg + 2'd1;
        if (cnt_reg == ITER_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_ready = (state_reg == IDLE);
  assign o_valid = (state_reg == DONE);
  assign o_prod  = {acc_hi_reg, mplr_reg};
endmodule

// File: tb/tb_mul_4bit_seq.sv
// Directed self-checking bench for mul_4bit_seq: reset, latency, backpressure, sweep, mid-run reset.
module tb_mul_4bit_seq;
  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [3:0] i_a = 4'd0;
  logic [3:0] i_b = 4'd0;
  logic       o_valid;
  logic       i_ready = 1'b1;
  logic [7:0] o_prod;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  mul_4bit_seq dut (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_prod  (o_prod)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents one operand pair for a single edge (E0), then counts edges until o_valid.
  // lat = number of edges after E0 at which o_valid is first seen (0 = right after E0).
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        output logic [7:0] prod, output int lat);
    i_a = a;
    i_b = b;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_a = 4'hx;
    i_b = 4'hx;
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(posedge i_clk); #1;
      lat++;
    end
    prod = o_prod;
  endtask

  initial begin
    logic [7:0] prod;
    int lat;
    int exp_zero_lat;

    // Reset default
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_prod", o_prod, 8'h00);
    i_rstn = 1'b1;
    @(posedge i_clk); #1;
    check("post_rst_ready", o_ready, 1);
    check("post_rst_prod", o_prod, 8'h00);
    $display("reset: ready=%0d valid=%0d prod=%02h", o_ready, o_valid, o_prod);

    // Basic multiply 3*5
    i_ready = 1'b1;
    run_op(4'd3, 4'd5, prod, lat);
    check("basic_lat", lat, 4);
    check("basic_prod", prod, 8'h0F);
    check("basic_ready_in_done", o_ready, 0);
    @(posedge i_clk); #1;
    check("basic_ready_back", o_ready, 1);
    check("basic_valid_drop", o_valid, 0);
    $display("op 3*5: prod=%02h lat=%0d", prod, lat);

    // Maximum operands
    run_op(4'd15, 4'd15, prod, lat);
    check("max_prod", prod, 8'hE1);
    check("max_lat", lat, 4);
    @(posedge i_clk); #1;
    $display("op 15*15: prod=%02h lat=%0d", prod, lat);

    // Backpressure 9*7
    i_ready = 1'b0;
    run_op(4'd9, 4'd7, prod, lat);
    check("bp_lat", lat, 4);
    for (int k = 0; k < 5; k++) begin
      @(posedge i_clk); #1;
      check("bp_hold_valid", o_valid, 1);
      check("bp_hold_prod", o_prod, 8'h3F);
      check("bp_hold_ready", o_ready, 0);
    end
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    check("bp_release_ready", o_ready, 1);
    check("bp_release_valid", o_valid, 0);
    $display("op 9*7 backpressure: prod=%02h", prod);

    // Zero operand 0*11
`ifdef MUL_EARLY_EXIT_EN
    exp_zero_lat = 0;  // DONE entered directly at the accept edge
`else
    exp_zero_lat = 4;
`endif
    run_op(4'd0, 4'd11, prod, lat);
    check("zero_prod", prod, 8'h00);
    check("zero_lat", lat, exp_zero_lat);
    @(posedge i_clk); #1;
    $display("op 0*11: prod=%02h lat=%0d", prod, lat);

    // Reset mid-RUN: accept 6*6, reset after two iterations
    i_a = 4'd6;
    i_b = 4'd6;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    check("midrun_busy", o_ready, 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rstn = 1'b0;
    #1;
    check("midrun_rst_ready", o_ready, 1);
    check("midrun_rst_valid", o_valid, 0);
    check("midrun_rst_prod", o_prod, 8'h00);
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(posedge i_clk); #1;
    check("midrun_idle", o_ready, 1);
    run_op(4'd2, 4'd3, prod, lat);
    check("after_rst_prod", prod, 8'h06);
    check("after_rst_lat", lat, 4);
    @(posedge i_clk); #1;
    $display("op 2*3 after reset: prod=%02h lat=%0d", prod, lat);

    // Full sweep of operand pairs
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(a[3:0], b[3:0], prod, lat);
        check($sformatf("sweep_%0dx%0d", a, b), prod, a * b);
        @(posedge i_clk); #1;
      end
    end
    $display("sweep: 256 operand pairs issued");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
